ram_bist: RTL and testbench

RAM_BIST -- requirements
Module: ram_bist

---
 rtl/ram_bist.sv | 184 ++++++++++++++++++
 tb/tb_ram_bist.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/ram_bist.sv
// March-style RAM BIST: W(D) up, R/R/W(~D) up, R/R/W(D) down, R/R down.
// All outputs are registered; results are held in DONE until restart or reset.
module ram_bist #(
  parameter int unsigned     XLen       = 32,
  parameter int unsigned     NPos       = 128,
  parameter logic [XLen-1:0] Background = XLen'(32'hA5A5A5A5)
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        start_i,
  output logic [$clog2(NPos)-1:0]     a_o,
  output logic                        we_o,
  output logic [XLen-1:0]             wd_o,
  input  logic [XLen-1:0]             rd_i,
  output logic                        busy_o,
  output logic                        done_o,
  output logic                        pass_o,
  output logic [$clog2(NPos)-1:0]     fail_addr_o,
  output logic [XLen-1:0]             fail_exp_o,
  output logic [XLen-1:0]             fail_got_o,
  output logic [15:0]                 err_cnt_o
);

  localparam int unsigned NPosWidth = $clog2(NPos);
  localparam int unsigned PhWidth   = 2;
  localparam logic [NPosWidth-1:0] AddrLast = NPosWidth'(NPos - 1);
  localparam logic [PhWidth-1:0]   PhR1     = PhWidth'(0);
  localparam logic [PhWidth-1:0]   PhR2     = PhWidth'(1);
  localparam logic [PhWidth-1:0]   PhW      = PhWidth'(2);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    W_UP  = 3'd1,
    RW_UP = 3'd2,
    RW_DN = 3'd3,
    R_DN  = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t                 state, state_nxt;
  logic [NPosWidth-1:0]   addr, addr_nxt;
  logic [PhWidth-1:0]     phase, phase_nxt;
  logic [15:0]            err_nxt;
  logic [NPosWidth-1:0]   fail_addr_nxt;
  logic [XLen-1:0]        fail_exp_nxt, fail_got_nxt;
  logic                   done_nxt, pass_nxt, busy_nxt, we_nxt;
  logic [XLen-1:0]        wd_nxt;
  logic                   cmp_c;
  logic [XLen-1:0]        exp_c;

  // State and output registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      addr        <= '0;
      phase       <= '0;
      we_o        <= 1'b0;
      wd_o        <= '0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      pass_o      <= 1'b0;
      fail_addr_o <= '0;
      fail_exp_o  <= '0;
      fail_got_o  <= '0;
      err_cnt_o   <= '0;
    end else begin
      state       <= state_nxt;
      addr        <= addr_nxt;
      phase       <= phase_nxt;
      we_o        <= we_nxt;
      wd_o        <= wd_nxt;
      busy_o      <= busy_nxt;
      done_o      <= done_nxt;
      pass_o      <= pass_nxt;
      fail_addr_o <= fail_addr_nxt;
      fail_exp_o  <= fail_exp_nxt;
      fail_got_o  <= fail_got_nxt;
      err_cnt_o   <= err_nxt;
    end
  end

  assign a_o = addr;

  // Next-state, compare and registered-output decode
  always_comb begin
    state_nxt     = state;
    addr_nxt      = addr;
    phase_nxt     = phase;
    err_nxt       = err_cnt_o;
    fail_addr_nxt = fail_addr_o;
    fail_exp_nxt  = fail_exp_o;
    fail_got_nxt  = fail_got_o;
    done_nxt      = done_o;
    cmp_c         = 1'b0;
    exp_c         = Background;

    unique case (state)
      IDLE, DONE: begin
        if (start_i) begin
          state_nxt     = W_UP;
          addr_nxt      = '0;
          phase_nxt     = PhR1;
          err_nxt       = '0;
          fail_addr_nxt = '0;
          fail_exp_nxt  = '0;
          fail_got_nxt  = '0;
          done_nxt      = 1'b0;
        end
      end
      W_UP: begin
        if (addr == AddrLast) begin
          state_nxt = RW_UP;
          addr_nxt  = '0;
        end else begin
          addr_nxt = addr + NPosWidth'(1);
        end
      end
      RW_UP, RW_DN: begin
        exp_c = (state == RW_DN) ? ~Background : Background;
        cmp_c = (phase == PhR2);
        if (phase != PhW) begin
          phase_nxt = phase + PhWidth'(1);
        end else begin
          phase_nxt = PhR1;
          if (state == RW_UP) begin
            if (addr == AddrLast) begin
              state_nxt = RW_DN;
            end else begin
              addr_nxt = addr + NPosWidth'(1);
            end
          end else begin
            if (addr == '0) begin
              state_nxt = R_DN;
              addr_nxt  = AddrLast;
            end else begin
              addr_nxt = addr - NPosWidth'(1);
            end
          end
        end
      end
      R_DN: begin
        cmp_c = (phase == PhR2);
        if (phase == PhR1) begin
          phase_nxt = PhR2;
        end else begin
          phase_nxt = PhR1;
          if (addr == '0) begin
            state_nxt = DONE;
            done_nxt  = 1'b1;
          end else begin
            addr_nxt = addr - NPosWidth'(1);
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        addr_nxt  = '0;
        phase_nxt = PhR1;
      end
    endcase

    // A zero error count means no mismatch has been captured since start
    if (cmp_c && (rd_i != exp_c)) begin
      if (err_cnt_o != 16'hFFFF) begin
        err_nxt = err_cnt_o + 16'd1;
      end
      if (err_cnt_o == 16'd0) begin
        fail_addr_nxt = addr;
        fail_exp_nxt  = exp_c;
        fail_got_nxt  = rd_i;
      end
    end

    busy_nxt = (state_nxt != IDLE) && (state_nxt != DONE);
    we_nxt   = (state_nxt == W_UP) ||
               (((state_nxt == RW_UP) || (state_nxt == RW_DN)) && (phase_nxt == PhW));
    wd_nxt   = '0;
    if (we_nxt) begin
      wd_nxt = (state_nxt == RW_UP) ? ~Background : Background;
    end
    pass_nxt = (state_nxt == DONE) && (err_nxt == 16'd0);
  end

endmodule

// File: tb/tb_ram_bist.sv
// Directed bench for ram_bist with a behavioural RAM that can inject
// a stuck bit, address aliasing, or use registered reads.
module tb_ram_bist;

  localparam int unsigned NPos = 128;
  localparam int unsigned AW   = 7;
  localparam logic [31:0] D    = 32'hA5A5A5A5;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] a;
  logic          we;
  logic [31:0]   wd;
  logic [31:0]   rd;
  logic          busy, done, pass;
  logic [AW-1:0] fail_addr;
  logic [31:0]   fail_exp, fail_got;
  logic [15:0]   err_cnt;

  int checks   = 0;
  int failures = 0;

  ram_bist #(.XLen(32), .NPos(NPos), .Background(D)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start),
    .a_o(a), .we_o(we), .wd_o(wd), .rd_i(rd),
    .busy_o(busy), .done_o(done), .pass_o(pass),
    .fail_addr_o(fail_addr), .fail_exp_o(fail_exp), .fail_got_o(fail_got),
    .err_cnt_o(err_cnt)
  );

  always #5 clk = ~clk;

  // RAM model: mode 1 forces bit0 at address 5, mode 2 drops address bit 6
  logic [31:0]   mem [NPos];
  int            fault_mode = 0;
  bit            reg_read   = 1'b0;
  logic [AW-1:0] ea;
  logic [31:0]   rd_comb, rd_q;

  assign ea      = (fault_mode == 2) ? (a & 7'h3F) : a;
  assign rd_comb = mem[ea] | {31'b0, (fault_mode == 1) && (a == 7'd5)};
  assign rd      = reg_read ? rd_q : rd_comb;

  always @(posedge clk) begin
    if (we) mem[ea] <= wd;
    rd_q <= rd_comb;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Expected bus activity for busy cycle i (0-based from the start edge)
  task automatic exp_seq(input int i, output logic [AW-1:0] ea_o,
                         output logic ewe, output logic [31:0] ewd);
    int j;
    ewe = 1'b0;
    ewd = 32'h0;
    if (i < 128) begin
      ea_o = AW'(i); ewe = 1'b1; ewd = D;
    end else if (i < 512) begin
      j = i - 128; ea_o = AW'(j / 3); ewe = (j % 3 == 2); ewd = ewe ? ~D : 32'h0;
    end else if (i < 896) begin
      j = i - 512; ea_o = AW'(127 - j / 3); ewe = (j % 3 == 2); ewd = ewe ? D : 32'h0;
    end else begin
      j = i - 896; ea_o = AW'(127 - j / 2);
    end
  endtask

  // Start a test, follow it to completion and check duration and bus sequence
  task automatic run_test(input string tag, input int poke_at);
    int busy_n = 0, we_n = 0, seq_err = 0;
    bit timeout = 1'b1;
    logic [AW-1:0] xa;
    logic xwe;
    logic [31:0] xwd;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    check({tag, "_done_clr"}, 32'(done), 32'd0);
    for (int i = 0; i < 2000; i++) begin
      if (!busy) begin
        timeout = 1'b0;
        break;
      end
      exp_seq(i, xa, xwe, xwd);
      if (a !== xa || we !== xwe || wd !== xwd) seq_err++;
      if (we) we_n++;
      busy_n++;
      start = (i == poke_at);
      @(negedge clk);
    end
    start = 1'b0;
    check({tag, "_timeout"}, 32'(timeout), 32'd0);
    check({tag, "_busy_cycles"}, 32'(busy_n), 32'd1152);
    check({tag, "_we_cycles"}, 32'(we_n), 32'd384);
    check({tag, "_seq_err"}, 32'(seq_err), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_idle_addr"}, 32'(a), 32'd0);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_pass", 32'(pass), 32'd0);
    check("rst_we", 32'(we), 32'd0);
    check("rst_addr", 32'(a), 32'd0);
    check("rst_err", 32'(err_cnt), 32'd0);

    // Fault-free, combinational read
    run_test("clean", -1);
    check("clean_pass", 32'(pass), 32'd1);
    check("clean_err", 32'(err_cnt), 32'd0);
    check("clean_fail_got", fail_got, 32'd0);

    // Stuck bit0 at address 5; start from DONE also exercises restart
    fault_mode = 1;
    run_test("stuck", -1);
    check("stuck_err", 32'(err_cnt), 32'd1);
    check("stuck_addr", 32'(fail_addr), 32'd5);
    check("stuck_exp", fail_exp, 32'h5A5A5A5A);
    check("stuck_got", fail_got, 32'h5A5A5A5B);
    check("stuck_pass", 32'(pass), 32'd0);

    // Address bit 6 ignored
    fault_mode = 2;
    run_test("alias", -1);
    check("alias_addr", 32'(fail_addr), 32'd64);
    check("alias_exp", fail_exp, 32'hA5A5A5A5);
    check("alias_got", fail_got, 32'h5A5A5A5A);
    check("alias_err_nz", 32'(err_cnt != 16'd0), 32'd1);
    check("alias_pass", 32'(pass), 32'd0);

    // Reset about 500 cycles into a test
    fault_mode = 0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (499) @(negedge clk);
    check("pre_rst_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_we", 32'(we), 32'd0);
    check("abort_err", 32'(err_cnt), 32'd0);
    check("abort_done", 32'(done), 32'd0);

    // Rerun after reset with a stray start pulse mid-test
    run_test("rerun_poke", 300);
    check("rerun_pass", 32'(pass), 32'd1);

    // Registered-read RAM
    reg_read = 1'b1;
    run_test("regrd", -1);
    check("regrd_pass", 32'(pass), 32'd1);
    check("regrd_err", 32'(err_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
